// File: rtl/alu_pkg.sv
// Shared op encoding and width default for the ALU slice.
// ALU_ROTATE_EN (when defined) enables OP_ROL; otherwise 4'b1011 is reserved.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOT  = 4'b0101,
      OP_SLTU = 4'b0110,
      OP_MOV  = 4'b0111,
      OP_SLL  = 4'b1000,
      OP_SRL  = 4'b1001,
      OP_SRA  = 4'b1010,
      OP_ROL  = 4'b1011
   } op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate datapath with shift-out bit.
// Rotate logic exists only when ALU_ROTATE_EN is defined.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] tr,
   input  logic [AW-1:0]    amount,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             so
);

   // One guard bit on the side bits leave from; it ends up holding the last bit out.
   logic        [WIDTH:0] w_sll;
   logic        [WIDTH:0] w_srl;
   logic signed [WIDTH:0] w_sra;

   assign w_sll = {1'b0, tr} << amount;
   assign w_srl = {tr, 1'b0} >> amount;
   assign w_sra = $signed({tr, 1'b0}) >>> amount;

`ifdef ALU_ROTATE_EN
   logic [2*WIDTH-1:0] w_rol;
   assign w_rol = {tr, tr} << amount;
`endif

   always_comb begin
      result = '0;
      so     = 1'b0;
      case (op)
         OP_SLL: {so, result} = w_sll;
         OP_SRL: {result, so} = w_srl;
         OP_SRA: {result, so} = w_sra;
`ifdef ALU_ROTATE_EN
         OP_ROL: begin
            result = w_rol[2*WIDTH-1:WIDTH];
            so     = (amount != '0) & w_rol[WIDTH];
         end
`endif
         default: begin
            result = '0;
            so     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: arithmetic/logic ops here, shifts in alu_shifter.
// Optional ROL selected by macro ALU_ROTATE_EN.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] tr,
   input  logic [WIDTH-1:0] sr,
   output logic [WIDTH-1:0] dr,
   output logic             cf
);

   localparam int AW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_dr;
   logic             r_cf;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_shres;
   logic             w_shso;
   logic [WIDTH-1:0] w_res;
   logic             w_cf;

   // Extra top bit is the carry for add and the unsigned borrow for sub.
   assign w_add = {1'b0, tr} + {1'b0, sr};
   assign w_sub = {1'b0, tr} - {1'b0, sr};

   alu_shifter #(.WIDTH(WIDTH), .AW(AW)) u_shifter (
      .tr     (tr),
      .amount (sr[AW-1:0]),
      .op     (op),
      .result (w_shres),
      .so     (w_shso)
   );

   always_comb begin
      w_res = '0;
      w_cf  = 1'b0;
      case (op)
         OP_ADD:  {w_cf, w_res} = w_add;
         OP_SUB:  {w_cf, w_res} = w_sub;
         OP_AND:  w_res = tr & sr;
         OP_OR:   w_res = tr | sr;
         OP_XOR:  w_res = tr ^ sr;
         OP_NOT:  w_res = ~tr;
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
         OP_MOV:  w_res = sr;
         OP_SLL, OP_SRL, OP_SRA
`ifdef ALU_ROTATE_EN
         , OP_ROL
`endif
         : begin
            w_res = w_shres;
            w_cf  = w_shso;
         end
         default: begin
            w_res = '0;
            w_cf  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dr <= '0;
         r_cf <= 1'b0;
      end else begin
         r_dr <= w_res;
         r_cf <= w_cf;
      end
   end

   assign dr = r_dr;
   assign cf = r_cf;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops against a bit-loop model.
// Expectations for op 1011 follow ALU_ROTATE_EN.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [3:0]  op;
   logic [31:0] tr;
   logic [31:0] sr;
   logic [31:0] dr;
   logic        cf;

   int n_checks = 0;
   int n_fail   = 0;

   alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .tr    (tr),
      .sr    (sr),
      .dr    (dr),
      .cf    (cf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: arithmetic in 64-bit integers, shifts as one-bit-at-a-time loops.
   function automatic logic [32:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] t;
      logic [31:0] v;
      logic        c;
      int          n;
      v = 32'd0;
      c = 1'b0;
      n = int'(b % 32);
      case (o)
         4'd0: begin t = 64'(a) + 64'(b); v = t[31:0]; c = (t >= 64'h1_0000_0000); end
         4'd1: begin v = a - b; c = (a < b); end
         4'd2: v = a & b;
         4'd3: v = a | b;
         4'd4: v = a ^ b;
         4'd5: v = ~a;
         4'd6: v = (a < b) ? 32'd1 : 32'd0;
         4'd7: v = b;
         4'd8: begin v = a; for (int i = 0; i < n; i++) begin c = v[31]; v = v << 1; end end
         4'd9: begin v = a; for (int i = 0; i < n; i++) begin c = v[0]; v = v >> 1; end end
         4'd10: begin v = a; for (int i = 0; i < n; i++) begin c = v[0]; v = {v[31], v[31:1]}; end end
`ifdef ALU_ROTATE_EN
         4'd11: begin
            v = a;
            for (int i = 0; i < n; i++) v = {v[30:0], v[31]};
            c = (n != 0) ? v[0] : 1'b0;
         end
`endif
         default: begin v = 32'd0; c = 1'b0; end
      endcase
      return {c, v};
   endfunction

   // Drive one op away from the edge, then let the next rising edge capture it.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; tr = a; sr = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      issue(4'd0, 32'h1234_0000, 32'h0000_5678);
      n_checks++;
      if ({cf, dr} !== {1'b0, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL reset_pre: got cf=%0b dr=%h want cf=0 dr=12345678", cf, dr);
      end
      issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cf, dr} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_async: got cf=%0b dr=%h want 0/0", cf, dr);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({cf, dr} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got cf=%0b dr=%h want 0/0", cf, dr);
      end
      @(negedge clk);
      op = 4'd7; tr = 32'd0; sr = 32'hCAFE_F00D;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({cf, dr} !== 33'd0) begin
         n_fail++;
         $display("FAIL reset_release: got cf=%0b dr=%h want 0/0", cf, dr);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({cf, dr} !== {1'b0, 32'hCAFE_F00D}) begin
         n_fail++;
         $display("FAIL reset_first_capture: got cf=%0b dr=%h want cf=0 dr=cafef00d", cf, dr);
      end
   endtask

   task automatic test_arith_logic();
      logic [31:0] exp_dr [8] = '{32'd53, 32'd11, 32'd0, 32'd53, 32'd53, 32'hFFFF_FFDF, 32'd0, 32'd21};
      for (int i = 0; i < 8; i++) begin
         issue(4'(i), 32'd32, 32'd21);
         n_checks++;
         if ({cf, dr} !== {1'b0, exp_dr[i]}) begin
            n_fail++;
            $display("FAIL arith_op%0d: got cf=%0b dr=%h want cf=0 dr=%h", i, cf, dr, exp_dr[i]);
         end
      end
   endtask

   task automatic test_carry_borrow();
      issue(4'd0, 32'hFFFF_FFFF, 32'd1);
      n_checks++;
      if ({cf, dr} !== {1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL add_carry: got cf=%0b dr=%h want cf=1 dr=0", cf, dr);
      end
      issue(4'd1, 32'd21, 32'd32);
      n_checks++;
      if ({cf, dr} !== {1'b1, 32'hFFFF_FFF5}) begin
         n_fail++;
         $display("FAIL sub_borrow: got cf=%0b dr=%h want cf=1 dr=fffffff5", cf, dr);
      end
   endtask

   task automatic test_shift();
      issue(4'd8, 32'd32, 32'd3);
      n_checks++;
      if ({cf, dr} !== {1'b0, 32'd256}) begin
         n_fail++; $display("FAIL sll: got cf=%0b dr=%h want cf=0 dr=100", cf, dr);
      end
      issue(4'd9, 32'd32, 32'd3);
      n_checks++;
      if ({cf, dr} !== {1'b0, 32'd4}) begin
         n_fail++; $display("FAIL srl: got cf=%0b dr=%h want cf=0 dr=4", cf, dr);
      end
      issue(4'd10, 32'h8000_0000, 32'd3);
      n_checks++;
      if (dr !== 32'hF000_0000) begin
         n_fail++; $display("FAIL sra: got dr=%h want f0000000", dr);
      end
      issue(4'd9, 32'd5, 32'd3);
      n_checks++;
      if ({cf, dr} !== {1'b1, 32'd0}) begin
         n_fail++; $display("FAIL srl_out: got cf=%0b dr=%h want cf=1 dr=0", cf, dr);
      end
      issue(4'd8, 32'h4000_0001, 32'd2);
      n_checks++;
      if ({cf, dr} !== {1'b1, 32'd4}) begin
         n_fail++; $display("FAIL sll_out: got cf=%0b dr=%h want cf=1 dr=4", cf, dr);
      end
   endtask

   task automatic test_zero_reserved();
      issue(4'd8, 32'd7, 32'h20);
      n_checks++;
      if ({cf, dr} !== {1'b0, 32'd7}) begin
         n_fail++; $display("FAIL shift_zero: got cf=%0b dr=%h want cf=0 dr=7", cf, dr);
      end
      issue(4'd15, 32'hDEAD_BEEF, 32'h1234_5678);
      n_checks++;
      if ({cf, dr} !== 33'd0) begin
         n_fail++; $display("FAIL reserved: got cf=%0b dr=%h want 0/0", cf, dr);
      end
   endtask

   task automatic test_rotate();
      logic [32:0] want;
`ifdef ALU_ROTATE_EN
      want = {1'b1, 32'h0000_0003};
`else
      want = 33'd0;
`endif
      issue(4'd11, 32'h8000_0001, 32'd1);
      n_checks++;
      if ({cf, dr} !== want) begin
         n_fail++; $display("FAIL rol: got cf=%0b dr=%h want cf=%0b dr=%h", cf, dr, want[32], want[31:0]);
      end
   endtask

   // One op per cycle; each result checked after the edge that captures it.
   task automatic test_back_to_back();
      logic [3:0]  o;
      logic [31:0] a, b;
      logic [32:0] want;
      for (int k = 0; k < 300; k++) begin
         o = 4'($urandom_range(0, 15));
         a = $urandom;
         b = (k % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (k % 7 == 0) a = b;
         want = model(o, a, b);
         issue(o, a, b);
         n_checks++;
         if ({cf, dr} !== want) begin
            n_fail++;
            $display("FAIL random op=%0d tr=%h sr=%h: got cf=%0b dr=%h want cf=%0b dr=%h",
                     o, a, b, cf, dr, want[32], want[31:0]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; op = 4'd0; tr = 32'd0; sr = 32'd0;
      #1;
      n_checks++;
      if ({cf, dr} !== 33'd0) begin
         n_fail++; $display("FAIL reset_initial: got cf=%0b dr=%h want 0/0", cf, dr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      test_reset();
      test_arith_logic();
      test_carry_borrow();
      test_shift();
      test_zero_reserved();
      test_rotate();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
